// File: rtl/text_line_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : text_line_renderer
//  Purpose  : Renders the HUD text words as one line of 8x16 glyphs on the
//             VGA raster. A per-frame shadow copy of the text words keeps a
//             mid-frame update from tearing the line. Two-stage pipeline
//             around a synchronous font ROM: pixel presented in cycle N shows
//             up on text_on/text_pixel in cycle N+2.
//  Ports    :
//    Clk          in   system clock, one raster pixel per cycle
//    Reset        in   asynchronous active-high reset
//    reg_font     in   NUM_WORDS x 32-bit text words, word i at [32*i +: 32],
//                      byte0 of a word is its leftmost character
//    frame_start  in   one-cycle pulse, loads the shadow copy
//    DrawX/DrawY  in   raster coordinates of the pixel presented this cycle
//    font_addr    out  registered ROM address {code[6:0], row[3:0]}
//    font_data    in   ROM row for font_addr, valid the following cycle,
//                      bit7 is the leftmost pixel
//    text_on      out  registered: pixel lies inside the text line
//    text_pixel   out  foreground pixel, gated by text_on
//  Revision : 1.0  initial release
// ============================================================================
module text_line_renderer #(
  parameter int ORIGIN_X  = 16,
  parameter int ORIGIN_Y  = 8,
  parameter int NUM_WORDS = 7   // at most 8: character index is rx[7:3]
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [32*NUM_WORDS-1:0]   reg_font,
  input  logic                      frame_start,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  output logic [10:0]               font_addr,
  input  logic [7:0]                font_data,
  output logic                      text_on,
  output logic                      text_pixel
);

  // Region bounds, 11 bits wide so the upper bound cannot wrap.
  localparam logic [10:0] c_X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] c_X_HI = 11'(ORIGIN_X + 32 * NUM_WORDS);
  localparam logic [10:0] c_Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] c_Y_HI = 11'(ORIGIN_Y + 16);

  logic [32*NUM_WORDS-1:0] r_shadow;

  logic [10:0] w_x_ext;
  logic [10:0] w_y_ext;
  logic        w_hit;
  logic [7:0]  w_rx;
  logic [3:0]  w_ry;
  logic [2:0]  w_word;
  logic [1:0]  w_byte;
  logic [2:0]  w_col;
  logic [31:0] w_word_data;
  logic [7:0]  w_char;

  logic [10:0] r_font_addr;
  logic        r_s1_hit;
  logic [2:0]  r_s1_col;
  logic        r_s1_inv;
  logic        r_text_on;
  logic [2:0]  r_s2_col;
  logic        r_s2_inv;

  // --------------------------------------------------------------------------
  // Shadow copy: only changes on frame_start, so the decode below sees the
  // old contents for the pixel presented in the same cycle as the pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_shadow <= '0;
    end else if (frame_start) begin
      r_shadow <= reg_font;
    end
  end

  // --------------------------------------------------------------------------
  // Region test and character decode
  // --------------------------------------------------------------------------
  assign w_x_ext = {1'b0, DrawX};
  assign w_y_ext = {1'b0, DrawY};
  assign w_hit   = (w_x_ext >= c_X_LO) && (w_x_ext < c_X_HI) &&
                   (w_y_ext >= c_Y_LO) && (w_y_ext < c_Y_HI);

  // Only the low bits of the offsets matter inside the region; the upper
  // bits of a full subtraction would never be consumed.
  assign w_rx   = DrawX[7:0] - 8'(ORIGIN_X);
  assign w_ry   = DrawY[3:0] - 4'(ORIGIN_Y);
  assign w_word = w_rx[7:5];
  assign w_byte = w_rx[4:3];
  assign w_col  = w_rx[2:0];

  // Word index can exceed NUM_WORDS-1 outside the region; it then reads 0,
  // which is harmless because a miss forces the ROM address to 0.
  always_comb begin
    w_word_data = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (w_word == 3'(i)) begin
        w_word_data = r_shadow[32*i +: 32];
      end
    end
  end

  always_comb begin
    w_char = w_word_data[7:0];
    case (w_byte)
      2'd0:    w_char = w_word_data[7:0];
      2'd1:    w_char = w_word_data[15:8];
      2'd2:    w_char = w_word_data[23:16];
      default: w_char = w_word_data[31:24];
    endcase
  end

  // --------------------------------------------------------------------------
  // Stage 1: issue ROM address, carry column/inverse alongside it
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_font_addr <= '0;
      r_s1_hit    <= 1'b0;
      r_s1_col    <= '0;
      r_s1_inv    <= 1'b0;
    end else begin
      r_font_addr <= w_hit ? {w_char[6:0], w_ry} : 11'h000;
      r_s1_hit    <= w_hit;
      r_s1_col    <= w_col;
      r_s1_inv    <= w_char[7];
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: aligned with font_data returned by the ROM
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_text_on <= 1'b0;
      r_s2_col  <= '0;
      r_s2_inv  <= 1'b0;
    end else begin
      r_text_on <= r_s1_hit;
      r_s2_col  <= r_s1_col;
      r_s2_inv  <= r_s1_inv;
    end
  end

  assign font_addr  = r_font_addr;
  assign text_on    = r_text_on;
  // Bit 7 is the leftmost pixel, hence the reversed column index.
  assign text_pixel = r_text_on & (font_data[3'd7 - r_s2_col] ^ r_s2_inv);

endmodule
`default_nettype wire

// File: tb/tb_text_line_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_text_line_renderer
//  Purpose  : Self-checking bench for text_line_renderer (ORIGIN_X=16,
//             ORIGIN_Y=8, NUM_WORDS=7). Directed vector table plus
//             hand-written multi-cycle sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_text_line_renderer;

  localparam int c_NUM_WORDS = 7;

  logic                       Clk;
  logic                       Reset;
  logic [32*c_NUM_WORDS-1:0]  reg_font;
  logic                       frame_start;
  logic [9:0]                 DrawX;
  logic [9:0]                 DrawY;
  logic [10:0]                font_addr;
  logic [7:0]                 font_data;
  logic                       text_on;
  logic                       text_pixel;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  fd;
    logic [10:0] addr;
    logic        on;
    logic        pix;
  } vec_t;

  localparam int c_NV = 19;
  vec_t vecs [c_NV];

  text_line_renderer #(
    .ORIGIN_X  (16),
    .ORIGIN_Y  (8),
    .NUM_WORDS (c_NUM_WORDS)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .reg_font    (reg_font),
    .frame_start (frame_start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .font_addr   (font_addr),
    .font_data   (font_data),
    .text_on     (text_on),
    .text_pixel  (text_pixel)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one pixel and advance past the next rising edge.
  task automatic present(input logic [9:0] x, input logic [9:0] y, input logic fs);
    DrawX       = x;
    DrawY       = y;
    frame_start = fs;
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // x, y, font_data, expected font_addr, text_on, text_pixel
    // Shadow: word0 = 0x726F6353 ("Scor"), word6 = 0x00000083, others 0.
    vecs[0]  = '{10'd16,   10'd8,  8'h80, 11'h530, 1'b1, 1'b1}; // bit7 leftmost
    vecs[1]  = '{10'd17,   10'd8,  8'h80, 11'h530, 1'b1, 1'b0}; // col1 -> bit6
    vecs[2]  = '{10'd24,   10'd8,  8'hFF, 11'h630, 1'b1, 1'b1}; // 2nd char 'c'
    vecs[3]  = '{10'd16,   10'd13, 8'h00, 11'h535, 1'b1, 1'b0}; // row 5
    vecs[4]  = '{10'd32,   10'd8,  8'h7F, 11'h6F0, 1'b1, 1'b0}; // 'o', bit7 clear
    vecs[5]  = '{10'd40,   10'd8,  8'h80, 11'h720, 1'b1, 1'b1}; // 'r'
    vecs[6]  = '{10'd48,   10'd8,  8'h00, 11'h000, 1'b1, 1'b0}; // word1 blank
    vecs[7]  = '{10'd208,  10'd10, 8'h00, 11'h032, 1'b1, 1'b1}; // inverse blank
    vecs[8]  = '{10'd215,  10'd10, 8'h00, 11'h032, 1'b1, 1'b1};
    vecs[9]  = '{10'd216,  10'd10, 8'h00, 11'h002, 1'b1, 1'b0}; // code 0, no inv
    vecs[10] = '{10'd208,  10'd10, 8'h80, 11'h032, 1'b1, 1'b0}; // inv swaps
    vecs[11] = '{10'd209,  10'd10, 8'h80, 11'h032, 1'b1, 1'b1};
    vecs[12] = '{10'd239,  10'd8,  8'hFF, 11'h000, 1'b1, 1'b1}; // right edge
    vecs[13] = '{10'd16,   10'd23, 8'h01, 11'h53F, 1'b1, 1'b0}; // bottom row
    vecs[14] = '{10'd240,  10'd8,  8'hFF, 11'h000, 1'b0, 1'b0}; // past right
    vecs[15] = '{10'd15,   10'd8,  8'hFF, 11'h000, 1'b0, 1'b0}; // left of origin
    vecs[16] = '{10'd16,   10'd24, 8'hFF, 11'h000, 1'b0, 1'b0}; // below line
    vecs[17] = '{10'd16,   10'd7,  8'hFF, 11'h000, 1'b0, 1'b0}; // above line
    vecs[18] = '{10'd1023, 10'd1023, 8'hFF, 11'h000, 1'b0, 1'b0};

    // ---------------- reset state ----------------
    Reset       = 1'b1;
    reg_font    = '0;
    frame_start = 1'b0;
    DrawX       = '0;
    DrawY       = '0;
    font_data   = 8'hFF;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_font_addr",  font_addr, 11'h000);
    check("reset_text_on",    {10'b0, text_on}, 11'h000);
    check("reset_text_pixel", {10'b0, text_pixel}, 11'h000);
    Reset = 1'b0;

    // ---------------- shadow blank until frame_start ----------------
    reg_font[32*0 +: 32] = 32'h726F6353;
    reg_font[32*6 +: 32] = 32'h00000083;
    present(10'd16, 10'd8, 1'b0);
    check("blank_shadow_addr", font_addr, 11'h000);
    present(10'd0, 10'd0, 1'b1);   // load shadow

    // ---------------- vector table ----------------
    for (int i = 0; i < c_NV; i++) begin
      present(vecs[i].x, vecs[i].y, 1'b0);
      check($sformatf("vec%0d_font_addr", i), font_addr, vecs[i].addr);
      font_data = vecs[i].fd;
      present(10'd0, 10'd0, 1'b0);
      check($sformatf("vec%0d_text_on", i), {10'b0, text_on}, {10'b0, vecs[i].on});
      check($sformatf("vec%0d_text_pixel", i), {10'b0, text_pixel}, {10'b0, vecs[i].pix});
    end

    // ---------------- back-to-back inverse cell 208..215 ----------------
    font_data = 8'h00;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) present(10'(208 + i), 10'd10, 1'b0);
      else       present(10'd0, 10'd0, 1'b0);
      if (i < 8)  check($sformatf("stream%0d_font_addr", i), font_addr, 11'h032);
      if (i >= 1) check($sformatf("stream%0d_text_pixel", i - 1), {10'b0, text_pixel}, 11'h001);
    end
    present(10'd0, 10'd0, 1'b0);
    check("stream_end_text_on", {10'b0, text_on}, 11'h000);

    // ---------------- no tearing ----------------
    reg_font[32*0 +: 32] = 32'h00000041;
    present(10'd16, 10'd8, 1'b0);
    check("tear_no_fs", font_addr, 11'h530);
    present(10'd16, 10'd8, 1'b1);
    check("tear_same_cycle_fs", font_addr, 11'h530);
    present(10'd16, 10'd8, 1'b0);
    check("tear_after_fs", font_addr, 11'h410);

    // ---------------- reset mid-line ----------------
    font_data = 8'hFF;
    present(10'd16, 10'd8, 1'b0);
    present(10'd16, 10'd8, 1'b0);
    check("midrst_pre_text_on", {10'b0, text_on}, 11'h001);
    #1 Reset = 1'b1;
    #1;
    check("midrst_text_on",    {10'b0, text_on}, 11'h000);
    check("midrst_font_addr",  font_addr, 11'h000);
    check("midrst_text_pixel", {10'b0, text_pixel}, 11'h000);
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(posedge Clk);
    #1;
    check("postrst_font_addr",  font_addr, 11'h000);
    check("postrst_n1_text_on", {10'b0, text_on}, 11'h000);
    @(posedge Clk);
    #1;
    check("postrst_n2_text_on",    {10'b0, text_on}, 11'h001);
    check("postrst_n2_text_pixel", {10'b0, text_pixel}, 11'h001);
    check("postrst_n2_font_addr",  font_addr, 11'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
